// File: rtl/tiny_enc.sv
// Iterative 32-bit TEA-style cipher (16-bit halves, 64-bit key), one round per clock.
// Optional runtime key/delta programming over an APB write port when TEA_APB_EN is defined.
module tiny_enc #(
  parameter logic [63:0] KEY     = 64'h816fc52b09e74da3,
  parameter logic [15:0] DELTA   = 16'h0123,
  parameter int unsigned SHIFT   = 3,
  parameter int unsigned ROUNDS  = 32,
  parameter bit          DECRYPT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic [31:0] pwdata,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic        req_d, start, done;
  logic [15:0] v0, v1, sum, wd;
  logic [15:0] v0_nx, v1_nx, sum_nx, sum_init;
  logic [63:0] wk, key_r;
  logic [15:0] delta_r;
  logic [7:0]  count;
  logic        unused_apb;

  function automatic logic [15:0] f(input logic [15:0] x, ka, kb, s);
    return ((x << SHIFT) + ka) ^ (x + s) ^ ((x >> (SHIFT + 1)) + kb);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (req && !req_d) begin
        start    = 1'b1;
        state_nx = RUN;
      end
      RUN: if (count == 8'(ROUNDS)) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Decrypt walks the sum back down from delta*ROUNDS, undoing the halves in reverse order.
  assign sum_init = DECRYPT ? 16'(delta_r * 16'(ROUNDS)) : 16'h0000;

  always_comb begin
    v0_nx  = v0;
    v1_nx  = v1;
    sum_nx = sum;
    if (DECRYPT) begin
      v1_nx  = v1 - f(v0, wk[47:32], wk[63:48], sum);
      v0_nx  = v0 - f(v1_nx, wk[15:0], wk[31:16], sum);
      sum_nx = sum - wd;
    end else begin
      sum_nx = sum + wd;
      v0_nx  = v0 + f(v1, wk[15:0], wk[31:16], sum_nx);
      v1_nx  = v1 + f(v0_nx, wk[47:32], wk[63:48], sum_nx);
    end
  end

  // The final round lands on count==ROUNDS-1; the extra edge publishes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d <= 1'b0;
      ack   <= 1'b1;
      rdata <= '0;
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      wd    <= '0;
      wk    <= '0;
      count <= '0;
    end else begin
      req_d <= req;
      if (start) begin
        v1    <= wdata[31:16];
        v0    <= wdata[15:0];
        wk    <= key_r;
        wd    <= delta_r;
        sum   <= sum_init;
        count <= '0;
        ack   <= 1'b0;
      end else if (done) begin
        rdata <= {v1, v0};
        ack   <= 1'b1;
      end else if (state == RUN) begin
        v0    <= v0_nx;
        v1    <= v1_nx;
        sum   <= sum_nx;
        count <= count + 8'd1;
      end
    end
  end

`ifdef TEA_APB_EN
  // Writes only touch the config registers; the working copy is refreshed at the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r   <= KEY;
      delta_r <= DELTA;
    end else if (psel && penable && pwrite) begin
      case (paddr[3:2])
        2'd0:    key_r[31:0]  <= pwdata;
        2'd1:    key_r[63:32] <= pwdata;
        2'd2:    delta_r      <= pwdata[15:0];
        default: ;
      endcase
    end
  end
  assign unused_apb = ^{paddr[31:4], paddr[1:0]};
`else
  assign key_r      = KEY;
  assign delta_r    = DELTA;
  assign unused_apb = ^{pwdata, pwrite, paddr, psel, penable};
`endif

endmodule

// File: tb/tb_tiny_enc.sv
// Scoreboard bench for tiny_enc: an encryptor checked against a reference model and
// chained into a decryptor for round trips; APB programming is exercised when TEA_APB_EN is set.
module tb_tiny_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_e, rq_d;
  logic [31:0] wd_e, wd_d;
  logic        ack_e, ack_d;
  logic [31:0] rdata_e, rdata_d;
  logic [31:0] pwdata, paddr;
  logic        pwrite, psel, penable;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [63:0] cur_key   = 64'h816fc52b09e74da3;
  logic [15:0] cur_delta = 16'h0123;

  always #5 clk = ~clk;

  tiny_enc #(.DECRYPT(1'b0)) u_enc (
    .clk(clk), .rst(rst), .req(rq_e), .wdata(wd_e), .ack(ack_e), .rdata(rdata_e),
    .pwdata(pwdata), .pwrite(pwrite), .paddr(paddr), .psel(psel), .penable(penable));

  tiny_enc #(.DECRYPT(1'b1)) u_dec (
    .clk(clk), .rst(rst), .req(rq_d), .wdata(wd_d), .ack(ack_d), .rdata(rdata_d),
    .pwdata(pwdata), .pwrite(pwrite), .paddr(paddr), .psel(psel), .penable(penable));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tf(input logic [15:0] x, ka, kb, s);
    logic [15:0] a, b, c;
    a = (x << 3) + ka;
    b = x + s;
    c = (x >> 4) + kb;
    return a ^ b ^ c;
  endfunction

  function automatic logic [31:0] model_enc(input logic [31:0] blk, input logic [63:0] k,
                                            input logic [15:0] d);
    logic [15:0] a0, a1, s;
    a0 = blk[15:0];
    a1 = blk[31:16];
    s  = 16'h0;
    for (int i = 0; i < 32; i++) begin
      s  = s + d;
      a0 = a0 + tf(a1, k[15:0], k[31:16], s);
      a1 = a1 + tf(a0, k[47:32], k[63:48], s);
    end
    return {a1, a0};
  endfunction

  task automatic do_op(input bit dec, input logic [31:0] din, output logic [31:0] dout);
    int lat;
    @(negedge clk);
    if (dec) begin wd_d = din; rq_d = 1'b1; end
    else     begin wd_e = din; rq_e = 1'b1; end
    @(posedge clk); #1;
    chk(dec ? "dec_busy" : "enc_busy", {31'b0, dec ? ack_d : ack_e}, 32'd0);
    lat = 0;
    while ((dec ? ack_d : ack_e) == 1'b0 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(dec ? "dec_latency" : "enc_latency", 32'(lat), 32'd33);
    dout = dec ? rdata_d : rdata_e;
    @(negedge clk);
    rq_d = 1'b0;
    rq_e = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    logic [31:0] r, c, pt, prev, def_ct;
    int lat;
    rst = 1'b1; rq_e = 1'b0; rq_d = 1'b0; wd_e = '0; wd_d = '0;
    pwdata = '0; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_e", {31'b0, ack_e}, 32'd1);
    chk("rst_rdata_e", rdata_e, 32'd0);
    chk("rst_ack_d", {31'b0, ack_d}, 32'd1);
    chk("rst_rdata_d", rdata_d, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ack", {31'b0, ack_e}, 32'd1);

    // latency and known vector
    exp_q.push_back(model_enc(32'h41424344, cur_key, cur_delta));
    do_op(1'b0, 32'h41424344, r);
    chk("vec_enc", r, exp_q.pop_front());
    chk("vec_changed", {31'b0, r != 32'h41424344}, 32'd1);
    def_ct = model_enc(32'h41424344, cur_key, cur_delta);
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_hold", rdata_e, def_ct);
    exp_q.push_back(32'h41424344);
    do_op(1'b1, r, c);
    chk("vec_dec", c, exp_q.pop_front());

    // busy: a second req edge inside RUN is dropped
    prev = def_ct;
    pt = 32'h5a5b6162;
    exp_q.push_back(model_enc(pt, cur_key, cur_delta));
    @(negedge clk);
    wd_e = pt; rq_e = 1'b1;
    repeat (3) @(negedge clk);
    rq_e = 1'b0;
    repeat (2) @(negedge clk);
    rq_e = 1'b1; wd_e = 32'h7a7a7a7a;
    chk("busy_ack", {31'b0, ack_e}, 32'd0);
    chk("busy_hold", rdata_e, prev);
    lat = 0;
    while (ack_e == 1'b0 && lat < 400) begin @(posedge clk); #1; lat++; end
    chk("busy_done", {31'b0, ack_e}, 32'd1);
    chk("busy_result", rdata_e, exp_q.pop_front());
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", {31'b0, ack_e}, 32'd1);
    @(negedge clk) rq_e = 1'b0;

    // reset mid-operation
    @(negedge clk);
    wd_e = 32'h61626364; rq_e = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; rq_e = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, ack_e}, 32'd1);
    chk("midrst_rdata", rdata_e, 32'd0);
    @(negedge clk) rst = 1'b0;
    exp_q.push_back(model_enc(32'h61626364, cur_key, cur_delta));
    do_op(1'b0, 32'h61626364, r);
    chk("post_rst", r, exp_q.pop_front());

    // round trip on random printable bytes
    for (int i = 0; i < 250; i++) begin
      for (int b = 0; b < 4; b++) pt[b*8 +: 8] = 8'($urandom_range(65, 122));
      exp_q.push_back(model_enc(pt, cur_key, cur_delta));
      do_op(1'b0, pt, c);
      chk("rt_enc", c, exp_q.pop_front());
      exp_q.push_back(pt);
      do_op(1'b1, c, r);
      chk("rt_dec", r, exp_q.pop_front());
    end

`ifdef TEA_APB_EN
    apb_wr(32'h0, 32'h13572468);
    apb_wr(32'h4, 32'hcafef00d);
    apb_wr(32'h8, 32'h00009e37);
    apb_wr(32'hc, 32'hffffffff);
    cur_key   = {32'hcafef00d, 32'h13572468};
    cur_delta = 16'h9e37;
    exp_q.push_back(model_enc(32'h41424344, cur_key, cur_delta));
    do_op(1'b0, 32'h41424344, c);
    chk("apb_enc", c, exp_q.pop_front());
    chk("apb_diff", {31'b0, c != def_ct}, 32'd1);
    exp_q.push_back(32'h41424344);
    do_op(1'b1, c, r);
    chk("apb_dec", r, exp_q.pop_front());
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
